// File: rtl/irm_tx_pkg.sv
// irm_tx_pkg: shared definitions for the NEC infrared transmitter.
//   - state_t     : frame sequencer states
//   - *_U         : state durations in NEC time units (562.5 us each)
//   - ADDR_*      : Avalon-MM register addresses
//   - is_mark()   : true for states that drive the emitter
package irm_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      REP_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } state_t;

   localparam logic [4:0] LEAD_MARK_U  = 5'd16;
   localparam logic [4:0] LEAD_SPACE_U = 5'd8;
   localparam logic [4:0] REP_SPACE_U  = 5'd4;
   localparam logic [4:0] BIT0_SPACE_U = 5'd1;
   localparam logic [4:0] BIT1_SPACE_U = 5'd3;
   localparam logic [4:0] MARK_U       = 5'd1;

   localparam logic ADDR_DATA = 1'b0;
   localparam logic ADDR_CTRL = 1'b1;

   function automatic logic is_mark(input state_t s);
      return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
   endfunction

endpackage

// File: rtl/irm_tx_carrier.sv
// irm_tx_carrier: ~38 kHz carrier generator for the NEC transmitter.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   restart    : forces the phase counter to 0 on the next edge
//   on         : carrier level, high for the first HIGH cycles of each DIV period
module irm_tx_carrier
   import irm_tx_pkg::*;
#(
   parameter int DIV  = 1316,
   parameter int HIGH = 439
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic on
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || restart)          cnt <= '0;
      else if (cnt == CW'(DIV - 1))  cnt <= '0;
      else                           cnt <= cnt + 1'b1;
   end

   assign on = (cnt < CW'(HIGH));

endmodule

// File: rtl/irm_tx_nec.sv
// irm_tx_nec: NEC-format IR transmitter with an Avalon-MM slave.
// Writing DATA while idle sends leader, 32 bits LSB first and a stop mark;
// writing CTRL bit0=1 while idle sends a repeat frame. irq rises at frame end.
// Optional build macro IRM_TX_CARRIER_EN gates marks with the carrier;
// without it marks are a solid 1 (baseband envelope).
// Ports:
//   clk, reset          : 50 MHz clock, synchronous active-high reset
//   irq                 : level interrupt, set at frame end, cleared by CTRL write
//   s_cs_n, s_address   : chip select (active low), 0=DATA 1=CTRL/STATUS
//   s_read, s_readdata  : read strobe, combinational read data
//   s_write, s_writedata: write strobe and data
//   ir_tx               : IR LED drive, 1 = emitter on
module irm_tx_nec
   import irm_tx_pkg::*;
#(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_HIGH = 439
) (
   input  logic        clk,
   input  logic        reset,
   output logic        irq,
   input  logic        s_cs_n,
   input  logic        s_address,
   input  logic        s_read,
   output logic [31:0] s_readdata,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic        ir_tx
);

   localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   if (CARRIER_HIGH >= CARRIER_DIV) begin : g_bad_carrier
      $error("irm_tx_nec: CARRIER_HIGH must be below CARRIER_DIV");
   end

   state_t        state;
   logic [UW-1:0] unit_cnt;
   logic [4:0]    unit_num;
   logic [4:0]    bit_idx;
   logic [4:0]    state_len;
   logic [31:0]   data_q;
   logic [31:0]   shift_q;
   logic          rep_q;
   logic          rejected;
   logic          busy, data_wr, ctrl_wr, start_data, start_rep;
   logic          unit_wrap, adv, carrier_on;

   assign busy       = (state != IDLE);
   assign data_wr    = ~s_cs_n & s_write & (s_address == ADDR_DATA);
   assign ctrl_wr    = ~s_cs_n & s_write & (s_address == ADDR_CTRL);
   assign start_data = data_wr & ~busy;
   assign start_rep  = ctrl_wr & s_writedata[0] & ~busy;
   assign unit_wrap  = (unit_cnt == UW'(UNIT_CYCLES - 1));

   // Duration of the current state; a bit space depends on the bit in flight.
   always_comb begin
      state_len = MARK_U;
      case (state)
         LEAD_MARK:  state_len = LEAD_MARK_U;
         LEAD_SPACE: state_len = LEAD_SPACE_U;
         REP_SPACE:  state_len = REP_SPACE_U;
         BIT_SPACE:  state_len = shift_q[0] ? BIT1_SPACE_U : BIT0_SPACE_U;
         default:    state_len = MARK_U;
      endcase
   end

   assign adv = busy & unit_wrap & (unit_num == state_len - 5'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         unit_cnt <= '0;
         unit_num <= '0;
         bit_idx  <= '0;
         data_q   <= '0;
         shift_q  <= '0;
         rep_q    <= 1'b0;
         rejected <= 1'b0;
         irq      <= 1'b0;
      end else begin
         // Clear first so that a same-edge set (frame end / reject) wins.
         if (ctrl_wr) begin
            irq      <= 1'b0;
            rejected <= 1'b0;
         end
         if (busy && (data_wr || (ctrl_wr && s_writedata[0])))
            rejected <= 1'b1;
         if (adv && state == STOP_MARK)
            irq <= 1'b1;

         if (start_data) begin
            data_q  <= s_writedata;
            shift_q <= s_writedata;
            rep_q   <= 1'b0;
            state   <= LEAD_MARK;
         end else if (start_rep) begin
            rep_q   <= 1'b1;
            state   <= LEAD_MARK;
         end

         // Every state ends on a unit wrap, so unit_cnt is 0 whenever idle.
         if (busy) begin
            unit_cnt <= unit_wrap ? '0 : unit_cnt + 1'b1;
            if (unit_wrap)
               unit_num <= adv ? 5'd0 : unit_num + 5'd1;
         end

         if (adv) begin
            case (state)
               LEAD_MARK:  state <= rep_q ? REP_SPACE : LEAD_SPACE;
               LEAD_SPACE: begin
                  state   <= BIT_MARK;
                  bit_idx <= '0;
               end
               REP_SPACE:  state <= STOP_MARK;
               BIT_MARK:   state <= BIT_SPACE;
               BIT_SPACE: begin
                  shift_q <= shift_q >> 1;
                  bit_idx <= bit_idx + 5'd1;
                  state   <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
               end
               default:    state <= IDLE;
            endcase
         end
      end
   end

`ifdef IRM_TX_CARRIER_EN
   // Restart on every state change so each mark opens with a high phase.
   irm_tx_carrier #(
      .DIV  (CARRIER_DIV),
      .HIGH (CARRIER_HIGH)
   ) u_carrier (
      .clk     (clk),
      .reset   (reset),
      .restart (start_data | start_rep | adv),
      .on      (carrier_on)
   );
`else
   assign carrier_on = 1'b1;
`endif

   assign ir_tx = is_mark(state) & carrier_on;

   always_comb begin
      s_readdata = '0;
      if (~s_cs_n & s_read)
         s_readdata = (s_address == ADDR_CTRL) ? {29'b0, rejected, irq, busy} : data_q;
   end

endmodule
